dm_access_ctrl: RTL and testbench

- Initiator-side controller that drives the 1 KB byte-addressed data memory on behalf of the CPU's MEM stage.
- Accepts one load/store request at a time and sequences the memory's addr, din, we and sbsel lines.
- The memory writes on the rising edge of its we input, so this block guarantees address and data are stable for a full cycle before we rises.
- On loads it captures the returned word and produces lw, lb (sign-extended) or lbu (zero-extended) results.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/load_ext.sv | 20 ++
 rtl/dm_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared CPU memory-side definitions: load/store opcodes, data-memory
// access FSM states and the data-memory address width.
package mips_pkg;

    localparam int DM_ADDR_W = 10;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SB  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } dm_state_e;

endpackage

// File: rtl/load_ext.sv
// Load result formatting: picks byte 0 of the fetched word and sign- or
// zero-extends it; words pass through unchanged.
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    always_comb begin
        result = word;
        case (op)
            OP_LB:   result = {{24{word[7]}}, word[7:0]};
            OP_LBU:  result = {24'd0, word[7:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sequences one load/store at a time so the
// edge-triggered memory write sees address/data settled a cycle before we.
module dm_access_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W      = DM_ADDR_W,
    parameter int CHECK_RANGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    output logic              dm_sbsel,
    input  logic [31:0]       dm_dout
);

    dm_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              err_q, err_d;
    logic [31:0]       cap_q, cap_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       dm_din_q, dm_din_d;
    logic              dm_sbsel_q, dm_sbsel_d;

    logic [31:0] ext_result;
    logic        illegal, misaligned, out_of_range, reject;

    load_ext u_load_ext (
        .word   (cap_q),
        .op     (op_q),
        .result (ext_result)
    );

    always_comb begin
        illegal      = (op > OP_SB);
        misaligned   = ((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00);
        out_of_range = (CHECK_RANGE != 0) && ((addr >> ADDR_W) != 32'd0);
        reject       = illegal || misaligned || out_of_range;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        err_d      = err_q;
        cap_d      = cap_q;
        rdata_d    = rdata_q;
        dm_addr_d  = dm_addr_q;
        dm_din_d   = dm_din_q;
        dm_sbsel_d = dm_sbsel_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d = op;
                    if (reject) begin
                        // Rejected requests never touch the memory-side lines.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d      = 1'b0;
                        dm_addr_d  = addr[ADDR_W-1:0];
                        dm_din_d   = wdata;
                        dm_sbsel_d = (op == OP_SB);
                        state_d    = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if ((op_q == OP_SW) || (op_q == OP_SB)) begin
                    state_d = ST_STROBE;
                end else begin
                    cap_d   = dm_dout;
                    state_d = ST_CAPTURE;
                end
            end
            ST_STROBE:  state_d = ST_RESP;
            ST_CAPTURE: begin
                // rdata only moves here so it stays put until the load's done.
                rdata_d = ext_result;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LW;
            err_q      <= 1'b0;
            cap_q      <= 32'd0;
            rdata_q    <= 32'd0;
            dm_addr_q  <= '0;
            dm_din_q   <= 32'd0;
            dm_sbsel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
            rdata_q    <= rdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_din_q   <= dm_din_d;
            dm_sbsel_q <= dm_sbsel_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_RESP);
    assign dm_we    = (state_q == ST_STROBE);
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign dm_addr  = dm_addr_q;
    assign dm_din   = dm_din_q;
    assign dm_sbsel = dm_sbsel_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: behavioural 1 KB memory, table of requests and a
// scoreboard of expected completions checked against done.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        ready, done, err, dm_we, dm_sbsel;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;

    dm_access_ctrl #(.ADDR_W(10), .CHECK_RANGE(1)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_sbsel(dm_sbsel), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory writes on the rising edge of we; reads are combinational.
    logic [7:0] mem [1024] = '{default: 8'h00};
    always @(posedge dm_we) begin
        mem[dm_addr] <= dm_din[7:0];
        if (!dm_sbsel) begin
            mem[dm_addr + 10'd1] <= dm_din[15:8];
            mem[dm_addr + 10'd2] <= dm_din[23:16];
            mem[dm_addr + 10'd3] <= dm_din[31:24];
        end
    end
    always_comb dm_dout = {mem[dm_addr + 10'd3], mem[dm_addr + 10'd2],
                           mem[dm_addr + 10'd1], mem[dm_addr]};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tv[15];
    logic [7:0]  ref_mem [1024];
    logic [31:0] exp_last;
    logic [9:0]  st_addr, prev_addr;
    logic [31:0] st_wdata, prev_din;
    logic        st_sbsel, prev_sbsel, prev_we;
    int          checks = 0, failures = 0;
    int          we_seen = 0, we_exp = 0, last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input logic e, input logic [31:0] r, input bit hold);
        int n = 0;
        exp_t x;
        req = 1'b1; op = o; addr = a; wdata = w;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            req = 1'b0;
            return;
        end
        if (!e && (o == 3'd1 || o == 3'd4)) begin
            st_addr = a[9:0]; st_wdata = w; st_sbsel = (o == 3'd4);
            we_exp++;
            ref_mem[a[9:0]] = w[7:0];
            if (o == 3'd1) begin
                ref_mem[a[9:0] + 10'd1] = w[15:8];
                ref_mem[a[9:0] + 10'd2] = w[23:16];
                ref_mem[a[9:0] + 10'd3] = w[31:24];
            end
        end
        if (!e && (o == 3'd0 || o == 3'd2 || o == 3'd3)) exp_last = r;
        x.rdata = exp_last; x.err = e; x.acc = cyc; x.lat = e ? 1 : 3;
        sb_q.push_back(x);
        last_acc = cyc;
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
        chk("drain_pending", sb_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
        exp_last = 32'd0;
        st_addr = '0; st_wdata = '0; st_sbsel = 1'b0;
        prev_addr = '0; prev_din = '0; prev_sbsel = 1'b0; prev_we = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        tv[0]  = '{3'd1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
        tv[1]  = '{3'd0, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        tv[2]  = '{3'd4, 32'h021, 32'h000000F0, 1'b0, 32'h0};
        tv[3]  = '{3'd2, 32'h021, 32'h0,        1'b0, 32'hFFFFFFF0};
        tv[4]  = '{3'd3, 32'h021, 32'h0,        1'b0, 32'h000000F0};
        tv[5]  = '{3'd3, 32'h022, 32'h0,        1'b0, 32'h00000000};
        tv[6]  = '{3'd0, 32'h013, 32'h0,        1'b1, 32'h0};
        tv[7]  = '{3'd1, 32'h400, 32'h11111111, 1'b1, 32'h0};
        tv[8]  = '{3'd6, 32'h010, 32'h22222222, 1'b1, 32'h0};
        tv[9]  = '{3'd0, 32'h020, 32'h0,        1'b0, 32'h0000F000};
        tv[10] = '{3'd4, 32'h3FF, 32'h0000005A, 1'b0, 32'h0};
        tv[11] = '{3'd3, 32'h3FF, 32'h0,        1'b0, 32'h0000005A};
        tv[12] = '{3'd1, 32'h024, 32'h12345685, 1'b0, 32'h0};
        tv[13] = '{3'd2, 32'h024, 32'h0,        1'b0, 32'hFFFFFF85};
        tv[14] = '{3'd0, 32'h3FC, 32'h0,        1'b0, 32'h5A000000};

        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        exp_t x;
                        x = sb_q.pop_front();
                        chk("rdata", rdata, x.rdata);
                        chk("err", 32'(err), 32'(x.err));
                        chk("latency", 32'(cyc - x.acc), 32'(x.lat));
                    end
                end
                if (dm_we) begin
                    if (prev_we) begin
                        chk("we_single_cycle", 32'(prev_we), 32'd0);
                    end else begin
                        we_seen++;
                        chk("setup_addr_stable", 32'(prev_addr), 32'(dm_addr));
                        chk("setup_din_stable", prev_din, dm_din);
                        chk("setup_sbsel_stable", 32'(prev_sbsel), 32'(dm_sbsel));
                        chk("strobe_addr", 32'(dm_addr), 32'(st_addr));
                        chk("strobe_din", dm_din, st_wdata);
                        chk("strobe_sbsel", 32'(dm_sbsel), 32'(st_sbsel));
                    end
                end
                prev_we = dm_we; prev_addr = dm_addr; prev_din = dm_din; prev_sbsel = dm_sbsel;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_dm_din", dm_din, 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_sbsel", 32'(dm_sbsel), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            issue(tv[i].op, tv[i].addr, tv[i].wdata, tv[i].err, tv[i].rdata, 1'b0);
            drain();
            @(negedge clk);
        end

        // Reset while the store strobe is high: no done, outputs back to reset values.
        issue(3'd1, 32'h030, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("strobe_reached", 32'(dm_we), 32'd1);
        rst = 1'b1;
        sb_q.delete();
        exp_last = 32'd0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dm_we", 32'(dm_we), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_dm_addr", 32'(dm_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(3'd0, 32'h030, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
        drain();
        @(negedge clk);

        // Continuous req with alternating SW/LW: accepts every 4 cycles.
        for (int k = 0; k < 6; k++) begin
            int prev_acc;
            prev_acc = last_acc;
            if (k % 2 == 0)
                issue(3'd1, 32'h040, 32'hA5000000 + 32'(k * 32'h1111), 1'b0, 32'h0, k != 5);
            else
                issue(3'd0, 32'h040, 32'h0, 1'b0, 32'hA5000000 + 32'((k - 1) * 32'h1111), k != 5);
            if (k > 0) chk("b2b_spacing", 32'(last_acc - prev_acc), 32'd4);
        end
        drain();
        repeat (2) @(negedge clk);

        chk("we_pulses", 32'(we_seen), 32'(we_exp));
        begin
            int bad = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_contents_bad_bytes", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
